// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : param_register_file
//  Purpose  : NREGS x DATA_W CPU register file with one write port, three
//             combinational read ports (A, B, D) and a PC register held at the
//             top index. Supports synchronous reset, gated PC loading, an
//             optional hardwired-zero R0 and optional write-first bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module param_register_file #(
    parameter int                DATA_W   = 32,
    parameter int                NREGS    = 16,
    parameter int                ADDR_W   = $clog2(NREGS),
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter bit                ZERO_R0  = 1'b0,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] PW,
    input  logic [ADDR_W-1:0] C,
    input  logic              RFLd,
    input  logic [DATA_W-1:0] PCin,
    input  logic              PCLd,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic [ADDR_W-1:0] SD,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic [DATA_W-1:0] PD,
    output logic [DATA_W-1:0] PCout
);

    localparam int                c_NGPR   = NREGS - 1;
    localparam logic [ADDR_W-1:0] c_PC_SEL = ADDR_W'(NREGS - 1);

    // General-purpose storage (indices 0..NREGS-2) and the PC (index NREGS-1)
    logic [DATA_W-1:0] r_gpr [c_NGPR];
    logic [DATA_W-1:0] r_pc;

    // Flat view of the whole file so the read ports index one array
    logic [DATA_W-1:0] w_file [NREGS];

    // Write decode
    logic w_r0_drop;
    logic w_wr_pc;
    logic w_wr_live;

    assign w_r0_drop = ZERO_R0 && (C == '0);
    assign w_wr_pc   = RFLd && (C == c_PC_SEL);
    // A write that will actually change state this edge (used for bypass)
    assign w_wr_live = RFLd && !Reset && !w_r0_drop;

    // General registers: cleared on reset, otherwise loaded from PW on a
    // decoded write; the R0 slot is never written when R0 is hardwired
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < c_NGPR; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NGPR; i++) begin
                if (RFLd && (C == ADDR_W'(i)) && !(ZERO_R0 && (i == 0))) begin
                    r_gpr[i] <= PW;
                end
            end
        end
    end

    // PC: reset wins, then an explicit register-file write, then fetch load
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc <= RESET_PC;
        end else if (w_wr_pc) begin
            r_pc <= PW;
        end else if (PCLd) begin
            r_pc <= PCin;
        end
    end

    generate
        for (genvar i = 0; i < c_NGPR; i++) begin : g_view
            assign w_file[i] = r_gpr[i];
        end
    endgenerate
    assign w_file[NREGS-1] = r_pc;

    // Read port selects gathered so one generate loop builds all three muxes
    logic [ADDR_W-1:0] w_sel [3];
    assign w_sel[0] = SA;
    assign w_sel[1] = SB;
    assign w_sel[2] = SD;

    generate
        for (genvar p = 0; p < 3; p++) begin : g_rd
            logic [DATA_W-1:0] w_val;
            // Stored value, overridden by in-flight write data, then by R0=0
            always_comb begin
                w_val = w_file[w_sel[p]];
                if (BYPASS && w_wr_live && (w_sel[p] == C)) begin
                    w_val = PW;
                end
                if (ZERO_R0 && (w_sel[p] == '0)) begin
                    w_val = '0;
                end
            end
        end
    endgenerate

    assign PA    = g_rd[0].w_val;
    assign PB    = g_rd[1].w_val;
    assign PD    = g_rd[2].w_val;
    // PCout always shows the stored PC, never forwarded data
    assign PCout = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_register_file
//  Purpose  : Self-checking bench for param_register_file. Two instances share
//             the stimulus: default build (BYPASS=1, ZERO_R0=0, RESET_PC=0)
//             and an alternate build (BYPASS=0, ZERO_R0=1, RESET_PC=0x100).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

    logic        CLK;
    logic        Reset;
    logic [31:0] PW;
    logic [3:0]  C;
    logic        RFLd;
    logic [31:0] PCin;
    logic        PCLd;
    logic [3:0]  SA, SB, SD;

    logic [31:0] pa1, pb1, pd1, pc1;
    logic [31:0] pa2, pb2, pd2, pc2;

    int errors = 0;
    int checks = 0;

    // Reference state: plain arrays of 16 words, index 15 is the PC
    logic [31:0] m1 [16];
    logic [31:0] m2 [16];

    param_register_file dut1 (
        .CLK(CLK), .Reset(Reset), .PW(PW), .C(C), .RFLd(RFLd),
        .PCin(PCin), .PCLd(PCLd), .SA(SA), .SB(SB), .SD(SD),
        .PA(pa1), .PB(pb1), .PD(pd1), .PCout(pc1)
    );

    param_register_file #(
        .RESET_PC(32'h100), .ZERO_R0(1'b1), .BYPASS(1'b0)
    ) dut2 (
        .CLK(CLK), .Reset(Reset), .PW(PW), .C(C), .RFLd(RFLd),
        .PCin(PCin), .PCLd(PCLd), .SA(SA), .SB(SB), .SD(SD),
        .PA(pa2), .PB(pb2), .PD(pd2), .PCout(pc2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read data for one build given the current inputs
    function automatic logic [31:0] model_read(input bit alt, input logic [3:0] sel);
        bit zero_r0 = alt;
        bit bypass  = !alt;
        bit dropped = zero_r0 && (C == 4'd0);
        if (zero_r0 && sel == 4'd0) return 32'd0;
        if (bypass && RFLd && !Reset && !dropped && sel == C) return PW;
        return alt ? m2[sel] : m1[sel];
    endfunction

    // Apply inputs on the falling edge and compare every output to the model
    task automatic drive(input logic rst, input logic rfld, input logic [3:0] c,
                         input logic [31:0] pw, input logic pcld, input logic [31:0] pcin,
                         input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] sd,
                         input bit do_check);
        @(negedge CLK);
        Reset = rst; RFLd = rfld; C = c; PW = pw; PCLd = pcld; PCin = pcin;
        SA = sa; SB = sb; SD = sd;
        #1;
        if (do_check) begin
            check("d1.PA", pa1, model_read(1'b0, SA));
            check("d1.PB", pb1, model_read(1'b0, SB));
            check("d1.PD", pd1, model_read(1'b0, SD));
            check("d1.PCout", pc1, m1[15]);
            check("d2.PA", pa2, model_read(1'b1, SA));
            check("d2.PB", pb2, model_read(1'b1, SB));
            check("d2.PD", pd2, model_read(1'b1, SD));
            check("d2.PCout", pc2, m2[15]);
        end
    endtask

    // Advance one clock and apply the architectural update rules to the model
    task automatic tick();
        @(posedge CLK);
        if (Reset) begin
            for (int i = 0; i < 15; i++) begin
                m1[i] = 32'd0;
                m2[i] = 32'd0;
            end
            m1[15] = 32'd0;
            m2[15] = 32'h100;
        end else begin
            if (RFLd && C == 4'd15) begin
                m1[15] = PW;
                m2[15] = PW;
            end else if (PCLd) begin
                m1[15] = PCin;
                m2[15] = PCin;
            end
            if (RFLd && C != 4'd15) begin
                m1[C] = PW;
                if (C != 4'd0) m2[C] = PW;
            end
        end
    endtask

    initial begin
        Reset = 1'b0; RFLd = 1'b0; PCLd = 1'b0; C = '0; PW = '0; PCin = '0;
        SA = '0; SB = '0; SD = '0;
        for (int i = 0; i < 16; i++) begin
            m1[i] = 32'd0;
            m2[i] = 32'd0;
        end

        // Reset with a write and PC load pending: both must be ignored
        drive(1, 1, 4'd3, 32'd5, 1, 32'd40, 4'd3, 4'd0, 4'd15, 1'b0);
        tick();
        drive(0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd3, 4'd0, 4'd15, 1'b1);
        check("rst.PA_R3", pa1, 32'd0);
        check("rst.PCout", pc1, 32'd0);
        check("rst.PD_pc_alt", pd2, 32'h100);
        check("rst.PCout_alt", pc2, 32'h100);
        tick();

        // Writes to R1, R2, R14 then read all three back
        drive(0, 1, 4'd1, 32'd3, 0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(0, 1, 4'd2, 32'd7, 0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(0, 1, 4'd14, 32'd83, 0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd1, 4'd2, 4'd14, 1'b1);
        check("wr.PA_R1", pa1, 32'd3);
        check("wr.PB_R2", pb1, 32'd7);
        check("wr.PD_R14", pd1, 32'd83);
        check("wr.PD_R14_alt", pd2, 32'd83);
        tick();

        // Bypass versus read-before-write on R10
        drive(0, 1, 4'd10, 32'd9, 0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(0, 1, 4'd10, 32'd16, 0, 32'd0, 4'd10, 4'd10, 4'd10, 1'b1);
        check("byp.PA_fwd", pa1, 32'd16);
        check("byp.PA_nofwd", pa2, 32'd9);
        tick();
        drive(0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd10, 4'd0, 4'd0, 1'b1);
        check("byp.PA_after", pa1, 32'd16);
        check("byp.PA_after_alt", pa2, 32'd16);
        tick();

        // PC loading sequence, hold, then RF-write vs PCLd collision
        drive(0, 0, 4'd0, 32'd0, 1, 32'd4, 4'd15, 4'd0, 4'd0, 1'b1);
        tick();
        drive(0, 0, 4'd0, 32'd0, 1, 32'd8, 4'd15, 4'd0, 4'd0, 1'b1);
        check("pc.load4", pc1, 32'd4);
        tick();
        drive(0, 0, 4'd0, 32'd0, 1, 32'd12, 4'd15, 4'd0, 4'd0, 1'b1);
        check("pc.load8", pc1, 32'd8);
        tick();
        drive(0, 0, 4'd0, 32'd0, 0, 32'd99, 4'd15, 4'd0, 4'd0, 1'b1);
        check("pc.load12", pc1, 32'd12);
        tick();
        drive(0, 1, 4'd15, 32'd35, 1, 32'd100, 4'd15, 4'd0, 4'd0, 1'b1);
        check("pc.hold", pc1, 32'd12);
        check("pc.byp_PA", pa1, 32'd35);
        check("pc.nobyp_PA", pa2, 32'd12);
        tick();
        drive(0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd15, 4'd0, 4'd0, 1'b1);
        check("pc.collision", pc1, 32'd35);
        check("pc.collision_alt", pc2, 32'd35);
        tick();

        // Hardwired R0 on the alternate build
        drive(0, 1, 4'd0, 32'hDEAD, 0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        check("r0.before_alt", pa2, 32'd0);
        check("r0.before_fwd", pa1, 32'hDEAD);
        tick();
        drive(0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        check("r0.after_alt", pa2, 32'd0);
        check("r0.after", pa1, 32'hDEAD);
        tick();

        // Mid-run reset discards a coincident write and PC load
        drive(0, 1, 4'd5, 32'd11, 0, 32'd0, 4'd5, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1, 1, 4'd5, 32'd73, 1, 32'd77, 4'd5, 4'd5, 4'd15, 1'b1);
        check("mrst.nobyp", pa1, 32'd11);
        tick();
        drive(0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd5, 4'd15, 4'd0, 1'b1);
        check("mrst.R5", pa1, 32'd0);
        check("mrst.PCout", pc1, 32'd0);
        check("mrst.PCout_alt", pc2, 32'h100);
        tick();

        // Randomized traffic, selects biased toward the write target
        for (int n = 0; n < 300; n++) begin
            logic [3:0] c_r;
            logic [3:0] s_r [3];
            c_r = 4'($urandom_range(0, 15));
            for (int k = 0; k < 3; k++) begin
                s_r[k] = ($urandom_range(0, 2) == 0) ? c_r : 4'($urandom_range(0, 15));
            end
            drive(($urandom_range(0, 24) == 0), 1'($urandom), c_r, $urandom,
                  1'($urandom), $urandom, s_r[0], s_r[1], s_r[2], 1'b1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
